// File: rtl/neurex_ctrl_pkg.sv
// Shared control-path types and default widths for the neurex compute and read controllers.
package neurex_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_ARRAY_DIM  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/input_rd_ctrl_skew_pipe.sv
// Diagonal skew pipeline: lane i delays its element and valid by i+1 register stages.
module skew_pipe
    import neurex_ctrl_pkg::*;
#(
    parameter int ARRAY_DIM  = DEF_ARRAY_DIM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] in_data,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] out_data,
    output logic [ARRAY_DIM-1:0]            out_valid
);

    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
        localparam int DEPTH = i + 1;

        logic [DATA_WIDTH-1:0]       lane_in;
        logic [DEPTH*DATA_WIDTH-1:0] d_sr;
        logic [DEPTH-1:0]            v_sr;

        // Zero the element on entry so invalid slots never carry stale SRAM data.
        assign lane_in = in_valid ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_sr <= '0;
                    v_sr <= '0;
                end else begin
                    d_sr <= lane_in;
                    v_sr <= in_valid;
                end
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_sr <= '0;
                    v_sr <= '0;
                end else begin
                    d_sr <= {d_sr[(DEPTH-1)*DATA_WIDTH-1:0], lane_in};
                    v_sr <= {v_sr[DEPTH-2:0], in_valid};
                end
            end
        end

        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = d_sr[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
        assign out_valid[i]                         = v_sr[DEPTH-1];
    end

endmodule

// File: rtl/input_rd_ctrl.sv
// Input-operand read controller: streams num_row SRAM rows into the systolic array with diagonal skew.
// Optional busy-cycle counter output perf_cycles when INPUT_RD_CTRL_PERF_EN is defined.
module input_rd_ctrl
    import neurex_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ARRAY_DIM  = DEF_ARRAY_DIM
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [DATA_WIDTH-1:0]           num_row_in,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] mem_rd_data,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] sys_in_data,
    output logic [ARRAY_DIM-1:0]            sys_in_valid,
    output logic                            busy,
    output logic                            rd_done
`ifdef INPUT_RD_CTRL_PERF_EN
    ,
    output logic [31:0]                     perf_cycles
`endif
);

    localparam int                 DRAIN_W    = $clog2(ARRAY_DIM + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ARRAY_DIM);

    rd_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     rows_left_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DRAIN_W-1:0]        drain_cnt_q;
    logic                      pend_q;
    logic                      zero_done_q;
    logic                      rd_valid_q;
    logic                      drain_last;
    logic                      accept;
    logic                      start_run;
    logic                      reading;
    logic                      active;

    logic [ARRAY_DIM*DATA_WIDTH-1:0] skew_data;
    logic [ARRAY_DIM-1:0]            skew_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A start taken in DRAIN's final cycle is parked in pend_q and launched via one IDLE cycle.
    always_comb begin
        state_d    = state_q;
        drain_last = (state_q == DRAIN) && (drain_cnt_q == DRAIN_LAST);
        accept     = en && (((state_q == IDLE) && !pend_q) || drain_last);
        start_run  = accept && (num_row_in != '0);
        unique case (state_q)
            IDLE:    if (pend_q || start_run) state_d = READ;
            READ:    if (rows_left_q == DATA_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_left_q <= '0;
            addr_q      <= '0;
            drain_cnt_q <= '0;
            pend_q      <= 1'b0;
            zero_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            zero_done_q <= accept && (num_row_in == '0);
            pend_q      <= drain_last && start_run;
            rd_valid_q  <= reading;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
            if (start_run) begin
                rows_left_q <= num_row_in;
                addr_q      <= base_addr;
            end else if (state_q == READ) begin
                rows_left_q <= rows_left_q - 1'b1;
                addr_q      <= addr_q + 1'b1;
            end
        end
    end

    assign reading = (state_q == READ);
    assign active  = (state_q == READ) || (state_q == DRAIN);

    skew_pipe #(
        .ARRAY_DIM  (ARRAY_DIM),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid_q),
        .in_data   (mem_rd_data),
        .out_data  (skew_data),
        .out_valid (skew_valid)
    );

    // Outputs are forced low while rst is asserted, not just from the cycle after.
    assign mem_rd_en    = !rst && reading;
    assign mem_rd_addr  = mem_rd_en ? addr_q : '0;
    assign busy         = !rst && active;
    assign rd_done      = !rst && (drain_last || zero_done_q);
    assign sys_in_valid = rst ? '0 : skew_valid;
    assign sys_in_data  = rst ? '0 : skew_data;

`ifdef INPUT_RD_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst || accept)                  perf_q <= '0;
        else if (active && (perf_q != '1)) perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles = rst ? '0 : perf_q;
`endif

endmodule

// File: tb/tb_input_rd_ctrl.sv
// Directed bench for input_rd_ctrl (ARRAY_DIM=4): per-cycle capture compared against hand-built timelines.
module tb_input_rd_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int AD = 4;
    localparam int NC = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [DW-1:0]   num_row_in;
    logic [AW-1:0]   base_addr;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic [AD*DW-1:0] mem_rd_data;
    logic [AD*DW-1:0] sys_in_data;
    logic [AD-1:0]   sys_in_valid;
    logic            busy;
    logic            rd_done;
`ifdef INPUT_RD_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic            s_en   [NC];
    logic            s_rst  [NC];
    logic [DW-1:0]   s_n    [NC];
    logic [AW-1:0]   s_base [NC];

    logic            o_rden [NC], e_rden [NC];
    logic [AW-1:0]   o_addr [NC], e_addr [NC];
    logic            o_busy [NC], e_busy [NC];
    logic            o_done [NC], e_done [NC];
    logic [AD-1:0]   o_valid[NC], e_valid[NC];
    logic [AD*DW-1:0] o_data[NC], e_data [NC];

    always #5 clk = ~clk;

    input_rd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ARRAY_DIM  (AD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .num_row_in   (num_row_in),
        .base_addr    (base_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .sys_in_data  (sys_in_data),
        .sys_in_valid (sys_in_valid),
        .busy         (busy),
        .rd_done      (rd_done)
`ifdef INPUT_RD_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    // SRAM content: lane i of address a holds {a, i, a[3:0]}.
    function automatic logic [DW-1:0] lane_val(input logic [AW-1:0] a, input int unsigned i);
        logic [3:0] li;
        li = i[3:0];
        return {a, li, a[3:0]};
    endfunction

    // One-cycle-latency SRAM; garbage when not read so the zeroing of invalid lanes is exercised.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            for (int i = 0; i < AD; i++) mem_rd_data[i*DW +: DW] <= lane_val(mem_rd_addr, i);
        end else begin
            mem_rd_data <= {$urandom(), $urandom()};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < NC; c++) begin
            s_en[c] = 1'b0; s_rst[c] = 1'b0; s_n[c] = '0; s_base[c] = '0;
            e_rden[c] = 1'b0; e_addr[c] = '0; e_busy[c] = 1'b0;
            e_done[c] = 1'b0; e_valid[c] = '0; e_data[c] = '0;
        end
    endtask

    task automatic sched(input int c, input int unsigned n, input logic [AW-1:0] b);
        s_en[c] = 1'b1; s_n[c] = DW'(n); s_base[c] = b;
    endtask

    // Expected timeline of a run whose en cycle is 'start'.
    task automatic add_run(input int start, input int n, input logic [AW-1:0] b);
        logic [AW-1:0] a;
        int            c;
        if (n == 0) begin
            e_done[start+1] = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            a = b + AW'(k);
            e_rden[start+1+k] = 1'b1;
            e_addr[start+1+k] = a;
            for (int i = 0; i < AD; i++) begin
                c = start + k + 3 + i;
                e_valid[c][i]        = 1'b1;
                e_data[c][i*DW +: DW] = lane_val(a, i);
            end
        end
        for (int c2 = start + 1; c2 <= start + n + AD + 1; c2++) e_busy[c2] = 1'b1;
        e_done[start+n+AD+1] = 1'b1;
    endtask

    task automatic zero_from(input int c0);
        for (int c = c0; c < NC; c++) begin
            e_rden[c] = 1'b0; e_addr[c] = '0; e_busy[c] = 1'b0;
            e_done[c] = 1'b0; e_valid[c] = '0; e_data[c] = '0;
        end
    endtask

    // Called just after a posedge; cycle c's inputs are applied, then outputs sampled at negedge.
    task automatic run_cycles(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            en = s_en[c]; num_row_in = s_n[c]; base_addr = s_base[c]; rst = s_rst[c];
            @(negedge clk);
            o_rden[c] = mem_rd_en; o_addr[c] = mem_rd_addr; o_busy[c] = busy;
            o_done[c] = rd_done; o_valid[c] = sys_in_valid; o_data[c] = sys_in_data;
            @(posedge clk);
            #1;
        end
        en = 1'b0; rst = 1'b0; num_row_in = '0; base_addr = '0;
    endtask

    task automatic compare_all(input string t, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            check($sformatf("%s rd_en@%0d", t, c), 64'(o_rden[c]), 64'(e_rden[c]));
            if (e_rden[c]) check($sformatf("%s addr@%0d", t, c), 64'(o_addr[c]), 64'(e_addr[c]));
            check($sformatf("%s busy@%0d", t, c), 64'(o_busy[c]), 64'(e_busy[c]));
            check($sformatf("%s done@%0d", t, c), 64'(o_done[c]), 64'(e_done[c]));
            check($sformatf("%s valid@%0d", t, c), 64'(o_valid[c]), 64'(e_valid[c]));
            check($sformatf("%s data@%0d", t, c), o_data[c], e_data[c]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; num_row_in = '0; base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rd_en", 64'(mem_rd_en), 64'd0);
        check("reset addr", 64'(mem_rd_addr), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(rd_done), 64'd0);
        check("reset valid", 64'(sys_in_valid), 64'd0);
        check("reset data", sys_in_data, 64'd0);
`ifdef INPUT_RD_CTRL_PERF_EN
        check("reset perf", 64'(perf_cycles), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // N=3 from 0x10
        clear_all(); sched(0, 3, 8'h10); add_run(0, 3, 8'h10);
        run_cycles(12); compare_all("n3", 12);
        check("n3 lane2 row1 valid", 64'(o_valid[6][2]), 64'd1);
        check("n3 lane2 row1 data", 64'(o_data[6][47:32]), 64'h1121);
        check("n3 done@8", 64'(o_done[8]), 64'd1);
`ifdef INPUT_RD_CTRL_PERF_EN
        check("n3 perf", 64'(perf_cycles), 64'd8);
`endif

        // N=0: immediate completion, no reads
        clear_all(); sched(0, 0, 8'h55); add_run(0, 0, 8'h55);
        run_cycles(6); compare_all("n0", 6);

        // N=4 from 0xFE wraps to 0x00
        clear_all(); sched(0, 4, 8'hFE); add_run(0, 4, 8'hFE);
        run_cycles(12); compare_all("wrap", 12);
        check("wrap addr@3", 64'(o_addr[3]), 64'h00);

        // en while busy is ignored
        clear_all(); sched(0, 5, 8'h40); sched(3, 7, 8'h80); add_run(0, 5, 8'h40);
        run_cycles(14); compare_all("ign", 14);

        // rst at cycle 4 aborts an N=6 run; fresh N=2 run at cycle 6
        clear_all(); sched(0, 6, 8'h60); s_rst[4] = 1'b1; sched(6, 2, 8'h70);
        add_run(0, 6, 8'h60); zero_from(4); add_run(6, 2, 8'h70);
        run_cycles(16); compare_all("abort", 16);

        // en coincident with rd_done: new first read two cycles later
        clear_all(); sched(0, 2, 8'h20); sched(7, 1, 8'h30);
        add_run(0, 2, 8'h20); add_run(8, 1, 8'h30);
        run_cycles(18); compare_all("b2b", 18);
        check("b2b done@7", 64'(o_done[7]), 64'd1);
        check("b2b rd_en@8", 64'(o_rden[8]), 64'd0);
        check("b2b rd_en@9", 64'(o_rden[9]), 64'd1);
        check("b2b done@14", 64'(o_done[14]), 64'd1);
`ifdef INPUT_RD_CTRL_PERF_EN
        check("b2b perf", 64'(perf_cycles), 64'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
